// File: rtl/joy_db15_responder.sv
// rtl/joy_db15_responder.sv - DB15 dual-joystick shift-register responder answering a JOY_CLK/JOY_LOAD serial poll.
// Optional status outputs (frame_cnt, short_frame) are built when DB15_RESP_STATUS_EN is defined.
module joy_db15_responder #(
    parameter int FRAME_BITS      = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int LOAD_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        JOY_DATA
`ifdef DB15_RESP_STATUS_EN
    ,
    output logic [7:0]  frame_cnt,
    output logic        short_frame
`endif
);

    localparam int   HALF      = FRAME_BITS / 2;
    localparam int   CW        = $clog2(FRAME_BITS) + 1;
    localparam logic LOAD_IDLE = (LOAD_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [FRAME_BITS-1:0]  sr_q, sr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   joy_data_q, joy_data_d;

    logic                   clk_rise;
    logic                   load_active;
    logic [FRAME_BITS-1:0]  frame_vec;

    // Synchronisers shift the raw pins in at stage 0; edges are taken from the last stage.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], JOY_CLK};
        load_sync_d = {load_sync_q[SYNC_STAGES-2:0], JOY_LOAD};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    end

    assign clk_rise    = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign load_active = load_sync_q[SYNC_STAGES-1] ^ LOAD_IDLE;
    assign frame_vec   = ~{joystick2[HALF-1:0], joystick1[HALF-1:0]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        // Load dominates everything, including a coincident shift clock.
        if (load_active) begin
            state_d = ST_LOAD;
            sr_d    = frame_vec;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_d  = {1'b1, sr_q[FRAME_BITS-1:1]};
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        joy_data_d = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) ? sr_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            clk_sync_q  <= '0;
            load_sync_q <= {SYNC_STAGES{LOAD_IDLE}};
            clk_prev_q  <= 1'b0;
            sr_q        <= '1;
            cnt_q       <= '0;
            joy_data_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            load_sync_q <= load_sync_d;
            clk_prev_q  <= clk_prev_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            joy_data_q  <= joy_data_d;
        end
    end

    assign JOY_DATA = joy_data_q;

`ifdef DB15_RESP_STATUS_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       short_frame_q, short_frame_d;

    // A frame is short when a new load interrupts SHIFT after at least one bit left.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        short_frame_d = short_frame_q;
        if ((state_q == ST_SHIFT) && (state_d == ST_DONE)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (load_active && (state_q == ST_SHIFT) && (cnt_q != '0)) begin
            short_frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            short_frame_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            short_frame_q <= short_frame_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign short_frame = short_frame_q;
`endif

endmodule

// File: tb/tb_joy_db15_responder.sv
// tb/tb_joy_db15_responder.sv - randomized self-checking bench for joy_db15_responder against a frame-level model.
`timescale 1ns/1ps
module tb_joy_db15_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        JOY_DATA;
`ifdef DB15_RESP_STATUS_EN
    logic [7:0]  frame_cnt;
    logic        short_frame;
`endif

    joy_db15_responder dut (
        .clk       (clk),
        .reset     (reset),
        .JOY_CLK   (JOY_CLK),
        .JOY_LOAD  (JOY_LOAD),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .JOY_DATA  (JOY_DATA)
`ifdef DB15_RESP_STATUS_EN
        ,
        .frame_cnt   (frame_cnt),
        .short_frame (short_frame)
`endif
    );

    always #10 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;

    // Frame-level model: the captured active-low word and how many bits the reader has clocked out.
    logic [31:0] m_word;
    int          m_rises;
    bit          m_loaded;
    int          m_frames;
    bit          m_short;

    function automatic logic exp_bit();
        if (!m_loaded || m_rises >= 32) return 1'b1;
        return m_word[m_rises];
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_loaded = 0;
        m_rises  = 0;
        m_frames = 0;
        m_short  = 0;
        m_word   = '1;
    endtask

    task automatic model_load_start();
        if (m_loaded && m_rises > 0 && m_rises < 32) m_short = 1;
        m_loaded = 1;
        m_rises  = 0;
        m_word   = ~{joystick2, joystick1};
    endtask

    task automatic model_rise();
        if (m_loaded && m_rises < 32) begin
            m_rises++;
            if (m_rises == 32) m_frames++;
        end
    endtask

    task automatic check_data(input string name);
        logic e;
        e = exp_bit();
        n_vec++;
        if (JOY_DATA !== e) begin
            n_err++;
            $display("FAIL %s: JOY_DATA=%b expected %b (bit %0d)", name, JOY_DATA, e, m_rises);
        end
    endtask

    task automatic check_status(input string name);
`ifdef DB15_RESP_STATUS_EN
        n_vec++;
        if (frame_cnt !== 8'(m_frames) || short_frame !== m_short) begin
            n_err++;
            $display("FAIL %s: frame_cnt=%0d short_frame=%b expected %0d %b",
                     name, frame_cnt, short_frame, 8'(m_frames), m_short);
        end
`else
        if (name.len() == 0) $display("status check with empty name");
`endif
    endtask

    task automatic do_load(input int h);
        JOY_LOAD = 1'b0;
        model_load_start();
        hold(h);
        JOY_LOAD = 1'b1;
        hold(h);
    endtask

    task automatic do_rise(input int hi, input int lo);
        JOY_CLK = 1'b1;
        hold(hi);
        model_rise();
        JOY_CLK = 1'b0;
        hold(lo);
    endtask

    task automatic test_reset();
        reset = 1'b1; JOY_CLK = 1'b0; JOY_LOAD = 1'b1;
        joystick1 = '0; joystick2 = '0;
        model_reset();
        hold(3);
        check_data("reset_data");
        reset = 1'b0;
        hold(2);
        check_data("post_reset_data");
        check_status("reset_status");
        for (int i = 0; i < 2; i++) begin
            do_rise(5, 5);
            check_data("idle_clk_ignored");
        end
    endtask

    task automatic test_fixed_frame();
        joystick1 = 16'h0005; joystick2 = 16'h8000;
        do_load(5);
        check_data("fixed_bit0");
        for (int i = 0; i < 34; i++) begin
            do_rise(5, 5);
            check_data($sformatf("fixed_rise%0d", i + 1));
        end
        check_status("fixed_status");
    endtask

    task automatic test_load_transparent();
        JOY_LOAD = 1'b0;
        joystick1 = 16'h0001; joystick2 = 16'h1234;
        model_load_start();
        hold(5);
        joystick1 = 16'h0002;
        model_load_start();
        hold(5);
        JOY_LOAD = 1'b1;
        hold(5);
        check_data("transparent_bit0");
        do_rise(5, 5);
        check_data("transparent_bit1");
        for (int i = 0; i < 31; i++) do_rise(5, 5);
        check_data("transparent_tail");
        check_status("transparent_status");
    endtask

    task automatic test_coincident();
        joystick1 = 16'($urandom); joystick2 = 16'($urandom);
        JOY_CLK  = 1'b1;
        JOY_LOAD = 1'b0;
        model_load_start();
        hold(6);
        check_data("coincident_during_load");
        JOY_LOAD = 1'b1;
        hold(6);
        check_data("coincident_after_load");
        JOY_CLK = 1'b0;
        hold(6);
        for (int i = 0; i < 33; i++) begin
            do_rise(5, 5);
            check_data($sformatf("coincident_rise%0d", i + 1));
        end
        check_status("coincident_status");
    endtask

    task automatic test_short_frame();
        joystick1 = 16'($urandom); joystick2 = 16'($urandom);
        do_load(5);
        for (int i = 0; i < 10; i++) do_rise(5, 5);
        check_data("short_bit10");
        joystick1 = 16'($urandom); joystick2 = 16'($urandom);
        do_load(5);
        check_data("short_reload_bit0");
        for (int i = 0; i < 32; i++) begin
            do_rise(5, 5);
            check_data($sformatf("short_full_rise%0d", i + 1));
        end
        check_status("short_status");
    endtask

    task automatic test_reset_mid_shift();
        joystick1 = 16'h0000; joystick2 = 16'h0000;
        do_load(5);
        for (int i = 0; i < 5; i++) do_rise(5, 5);
        reset = 1'b1;
        model_reset();
        hold(1);
        check_data("midreset_next_cycle");
        hold(2);
        reset = 1'b0;
        hold(1);
        check_data("midreset_released");
        check_status("midreset_status");
        for (int i = 0; i < 3; i++) begin
            do_rise(5, 5);
            check_data("midreset_idle_rise");
        end
    endtask

    task automatic test_random_frames();
        int nr;
        int h;
        for (int f = 0; f < 30; f++) begin
            joystick1 = 16'($urandom); joystick2 = 16'($urandom);
            h = int'($urandom_range(4, 7));
            do_load(h);
            check_data("rand_bit0");
            joystick1 = 16'($urandom); joystick2 = 16'($urandom);
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(32, 34));
            for (int i = 0; i < nr; i++) begin
                do_rise(int'($urandom_range(4, 7)), int'($urandom_range(4, 7)));
                check_data($sformatf("rand_f%0d_rise%0d", f, i + 1));
            end
            check_status("rand_status");
        end
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_load_transparent();
        test_coincident();
        test_short_frame();
        test_reset_mid_shift();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
